// File: rtl/rca_pkg.sv
// Shared constants and elaboration-time width check for the ripple-carry adder.
package rca_pkg;

  localparam int unsigned RCA_DEFAULT_WIDTH = 8;
  localparam int unsigned RCA_MAX_WIDTH     = 64;

  // True when the requested adder width is supported.
  function automatic bit rca_width_ok(input int unsigned width);
    return (width >= 1) && (width <= RCA_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/module_full_adder.sv
// Single-bit full adder: one stage of the ripple-carry chain.
module module_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic carry_i,
  output logic sum_o,
  output logic carry_o
);

  logic half_sum;

  // Sum and carry of one bit position; carry propagates when a ^ b.
  always_comb begin
    half_sum = a_i ^ b_i;
    sum_o    = half_sum ^ carry_i;
    carry_o  = (a_i & b_i) | (carry_i & half_sum);
  end

endmodule

// File: rtl/ripple_carry_adder.sv
// Parameterised ripple-carry adder built from an explicit chain of full adders.
// Define RCA_OUT_REG_EN to add a one-cycle output register with async reset;
// otherwise the block is purely combinational and clk_i/rst_i are unused.
module ripple_carry_adder
  import rca_pkg::*;
#(
  parameter int unsigned RCAWIDE = RCA_DEFAULT_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [RCAWIDE-1:0] a_i,
  input  logic [RCAWIDE-1:0] b_i,
  input  logic               carry_i,
  output logic [RCAWIDE-1:0] sum_o,
  output logic               carry_o
);

  // Reject unsupported widths at elaboration.
  if (!rca_width_ok(RCAWIDE)) begin : g_bad_width
    $error("ripple_carry_adder: RCAWIDE out of range 1..64");
  end

  // c[k] is the carry into stage k; c[RCAWIDE] is the final carry-out.
  logic [RCAWIDE:0]   c;
  logic [RCAWIDE-1:0] sum_c;

  assign c[0] = carry_i;

  for (genvar k = 0; k < RCAWIDE; k++) begin : g_stage
    module_full_adder u_fa (
      .a_i     (a_i[k]),
      .b_i     (b_i[k]),
      .carry_i (c[k]),
      .sum_o   (sum_c[k]),
      .carry_o (c[k+1])
    );
  end

`ifdef RCA_OUT_REG_EN
  logic [RCAWIDE-1:0] sum_q;
  logic               carry_q;

  // Output register; reset clears in-flight results immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_c;
      carry_q <= c[RCAWIDE];
    end
  end

  assign sum_o   = sum_q;
  assign carry_o = carry_q;
`else
  // Clock and reset have no function in combinational mode.
  logic unused_clk_rst;
  assign unused_clk_rst = clk_i ^ rst_i;

  assign sum_o   = sum_c;
  assign carry_o = c[RCAWIDE];
`endif

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder at widths 8 and 1.
// Follows RCA_OUT_REG_EN to pick combinational or one-cycle registered timing.
module tb_ripple_carry_adder;

`ifdef RCA_OUT_REG_EN
  localparam bit RegMode = 1'b1;
`else
  localparam bit RegMode = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       cin8 = 1'b0, cout8;
  logic       a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0, sum1, cout1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ripple_carry_adder #(.RCAWIDE(8)) dut8 (
    .clk_i   (clk),
    .rst_i   (rst),
    .a_i     (a8),
    .b_i     (b8),
    .carry_i (cin8),
    .sum_o   (sum8),
    .carry_o (cout8)
  );

  ripple_carry_adder #(.RCAWIDE(1)) dut1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .a_i     (a1),
    .b_i     (b1),
    .carry_i (cin1),
    .sum_o   (sum1),
    .carry_o (cout1)
  );

  task automatic check_eq(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition at width+1 bits.
  function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int unsigned total;
    total = int'(a) + int'(b) + int'(c);
    return total[8:0];
  endfunction

  function automatic logic [1:0] ref1(input logic a, input logic b, input logic c);
    int unsigned total;
    total = int'(a) + int'(b) + int'(c);
    return total[1:0];
  endfunction

  // Wait until the result for the current inputs is observable.
  task automatic settle();
    if (RegMode) begin
      @(posedge clk);
      #1;
    end else begin
      #10;
    end
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c);
    a8 = a; b8 = b; cin8 = c;
    settle();
    check_eq(tag, {cout8, sum8}, ref8(a, b, c));
  endtask

  task automatic run1(input string tag, input logic a, input logic b, input logic c);
    a1 = a; b1 = b; cin1 = c;
    settle();
    check_eq(tag, {7'd0, cout1, sum1}, {7'd0, ref1(a, b, c)});
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;

    // Reset state: registered outputs are zero, combinational ones ignore rst.
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b0;
    a1 = 1'b1;  b1 = 1'b0;  cin1 = 1'b0;
    #3;
    check_eq("reset_w8", {cout8, sum8}, RegMode ? 9'h000 : ref8(8'hFF, 8'h00, 1'b0));
    check_eq("reset_w1", {7'd0, cout1, sum1}, RegMode ? 9'h000 : 9'h001);
    @(negedge clk);
    rst = 1'b0;

    run8("zero",        8'h00, 8'h00, 1'b0);
    run8("no_carry",    8'h3C, 8'h42, 1'b0);
    run8("wrap",        8'hFF, 8'h01, 1'b0);
    run8("all_prop",    8'h55, 8'hAA, 1'b1);
    run8("max_ops",     8'hFF, 8'hFF, 1'b1);
    run8("ones_cin",    8'hFF, 8'h00, 1'b1);
    run8("msb_carry",   8'h80, 8'h80, 1'b0);
    run1("w1_all_ones", 1'b1, 1'b1, 1'b1);
    run1("w1_one",      1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 50; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      run8("rand_w8", ra, rb, rc);
    end
    for (int i = 0; i < 8; i++) begin
      run1("w1_exh", 1'(i >> 2), 1'(i >> 1), 1'(i));
    end

    // Reset between edges: registered outputs clear at once; comb unaffected.
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    check_eq("async_rst", {cout8, sum8}, RegMode ? 9'h000 : ref8(8'h12, 8'h34, 1'b1));
    @(posedge clk);
    #1;
    check_eq("rst_held", {cout8, sum8}, RegMode ? 9'h000 : ref8(8'h12, 8'h34, 1'b1));
    rst = 1'b0;
    run8("after_rst", 8'hC3, 8'h5A, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ripple_carry_adder.md
# ripple_carry_adder

Parameterised ripple-carry adder built from a chain of single-bit full adders. It computes `a_i + b_i + carry_i` and returns the `RCAWIDE`-bit sum and the carry-out. It is the reference arithmetic primitive for datapath blocks that need an explicit, inspectable carry chain. An optional output register stage is available for pipelined use.

## Interface
Parameters:
- `RCAWIDE`, default 8: operand and sum width in bits. Legal range is 1 to 64.

Ports:
- `clk_i`, input, 1 bit: the block's single clock, rising-edge active. Used only by the optional output register.
- `rst_i`, input, 1 bit: reset, asynchronous and active-high. Used only by the optional output register.
- `a_i`, input, `RCAWIDE` bits: operand A, unsigned.
- `b_i`, input, `RCAWIDE` bits: operand B, unsigned.
- `carry_i`, input, 1 bit: carry-in to bit 0.
- `sum_o`, output, `RCAWIDE` bits: low `RCAWIDE` bits of the total.
- `carry_o`, output, 1 bit: carry-out of bit `RCAWIDE-1`.

## Operation
- Arithmetic: `{carry_o, sum_o} = a_i + b_i + carry_i`, evaluated at `RCAWIDE+1` bits. No saturation; results wrap modulo 2^`RCAWIDE`, and the overflow is reported on `carry_o`.
- Structure of the chain:
  - `RCAWIDE` full-adder instances.
  - Stage k takes `a_i[k]`, `b_i[k]` and c[k]; it produces `sum_o[k]` and c[k+1].
  - c[0] = `carry_i`; `carry_o` = c[`RCAWIDE`].
- Full adder equations:
  - s = a ^ b ^ cin
  - cout = (a & b) | (cin & (a ^ b))
- The vector `+` operator is not used for the datapath. The chain must be an explicit generate loop of full-adder instances.
- Boundary cases:
  - All-ones + all-ones + 1 gives `sum_o` = all-ones and `carry_o` = 1.
  - All-ones + 0 + 1 propagates the carry through every stage.
  - With `RCAWIDE` = 1 the block degenerates to a single full adder.
- Inputs containing X propagate X to the affected and higher-order bits. No X-masking is applied.

## Timing
- Combinational mode (default):
  - Outputs depend only on the present inputs; zero cycles of latency.
  - `clk_i` and `rst_i` are ignored.
  - Worst-case path is `carry_i` or `a_i[0]`/`b_i[0]` through to `carry_o`, i.e. `RCAWIDE` carry stages.
  - Outputs must settle within 10 ns of an input change at the default width.
- Registered mode:
  - `sum_o` and `carry_o` are captured on the rising edge of `clk_i`; latency is exactly one cycle.
  - When `rst_i` is asserted, `sum_o` and `carry_o` go to 0 immediately, asynchronously to the clock, and stay 0 while `rst_i` is high.
  - If reset is asserted mid-stream, in-flight results are discarded.
  - The first valid result appears after the first rising edge following deassertion of `rst_i`.
  - There is no handshake or stall: a new operand set is accepted every cycle.

## Configuration
- `RCA_OUT_REG_EN` defined:
  - The output register stage is compiled in.
  - Outputs follow the registered-mode rules in Timing: one-cycle latency, async reset to 0.
- `RCA_OUT_REG_EN` undefined:
  - The block is purely combinational; there are no flops.
  - `clk_i` and `rst_i` are present but unused. Lint waivers for the unused inputs are required.

## Structure
- Shared package `rca_pkg` contains:
  - `RCA_DEFAULT_WIDTH` = 8.
  - `RCA_MAX_WIDTH` = 64.
  - An elaboration-time check helper that rejects `RCAWIDE` < 1 or `RCAWIDE` > `RCA_MAX_WIDTH`.
- Sub-module `module_full_adder`: ports `a_i`, `b_i`, `carry_i`, `sum_o`, `carry_o`, all 1 bit, purely combinational.
- Top-level contents:
  - the internal carry vector c[`RCAWIDE`:0];
  - the generate loop of `module_full_adder` instances;
  - the optional register block.

## Test plan
1. Combinational mode, `RCAWIDE` = 8:
   - a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0.
   - a=0x3C, b=0x42, cin=0 -> sum=0x7E, cout=0.
2. Carry propagation:
   - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
   - a=0x55, b=0xAA, cin=1 -> sum=0x00, cout=1. Every stage propagates.
3. Maximum operands: a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
4. Random comparison: 50 random vectors of a, b and cin, checked 10 ns after each is applied against `{cout, sum} = a + b + cin`. Any mismatch is fatal.
5. Registered mode (`RCA_OUT_REG_EN`):
   - Apply a=0x80, b=0x80, cin=0. After one rising edge: sum=0x00, cout=1.
   - Assert `rst_i` between edges -> outputs go to 0 without waiting for a clock edge.
6. Width corner: `RCAWIDE` = 1.
   - a=1, b=1, cin=1 -> sum=1, cout=1.
   - a=1, b=0, cin=0 -> sum=1, cout=0.
